dsp_mem_loader: RTL and testbench

DSP_MEM_LOADER -- requirements
Module: dsp_mem_loader

---
 rtl/dsp_mem_loader.sv | 175 +++++++++++++++++
 tb/tb_dsp_mem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_mem_loader.sv
// Loads command words (four beats) and envelope samples (one beat) into DSP
// unit memories, arbitrating round-robin between the host and the DMA engine.
module dsp_mem_loader #(
    parameter int N_CORES        = 4,
    parameter int CORE_SEL_WIDTH = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_WIDTH      = 128
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [2*CORE_SEL_WIDTH-1:0] req_core,
    input  logic [1:0]                  req_is_wave,
    input  logic [2*12-1:0]             req_addr,
    input  logic [2*CMD_WIDTH-1:0]      req_data,
    output logic [12:0]                 mem_write_addr,
    output logic [DATA_WIDTH-1:0]       mem_write_data,
    output logic [N_CORES-1:0]          mem_write_en,
    output logic                        busy,
    output logic                        err_core,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAVE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                beat_q, beat_d;
    logic                      last_gnt_q, last_gnt_d;
    logic [CORE_SEL_WIDTH-1:0] core_q, core_d;
    logic [11:0]               addr_q, addr_d;
    logic [CMD_WIDTH-1:0]      payload_q, payload_d;
    logic [12:0]               hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0]     hold_data_q, hold_data_d;
    logic                      err_q, err_d;

    logic                      gnt;
    logic                      accept;
    logic                      core_ok;
    logic                      in_beat;
    logic [CORE_SEL_WIDTH-1:0] sel_core;
    logic                      sel_wave;
    logic [11:0]               sel_addr;
    logic [CMD_WIDTH-1:0]      sel_data;
    logic [12:0]               beat_addr;
    logic [DATA_WIDTH-1:0]     beat_data;
    logic [N_CORES-1:0]        core_onehot;

    // Handshake: a request transfers on a rising edge where req_valid[r] and
    // req_ready[r] are both high; ready is only ever offered in IDLE, to the
    // single granted requester, and the requester holds its fields until then.
    always_comb begin
        gnt = 1'b0;
        if (req_valid == 2'b11) begin
            gnt = ~last_gnt_q;
        end else begin
            gnt = ~req_valid[0];
        end

        sel_core = gnt ? req_core[2*CORE_SEL_WIDTH-1:CORE_SEL_WIDTH]
                       : req_core[CORE_SEL_WIDTH-1:0];
        sel_wave = gnt ? req_is_wave[1] : req_is_wave[0];
        sel_addr = gnt ? req_addr[23:12] : req_addr[11:0];
        sel_data = gnt ? req_data[2*CMD_WIDTH-1:CMD_WIDTH] : req_data[CMD_WIDTH-1:0];

        accept  = (state_q == ST_IDLE) && (|req_valid) && !reset;
        core_ok = 32'(sel_core) < 32'(N_CORES);

        req_ready = 2'b00;
        if (accept) begin
            req_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        in_beat   = (state_q == ST_CMD) || (state_q == ST_WAVE);
        beat_addr = hold_addr_q;
        beat_data = hold_data_q;
        if (state_q == ST_CMD) begin
            beat_addr = {1'b0, 2'b00, beat_q, addr_q[7:0]};
            beat_data = payload_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH];
        end else if (state_q == ST_WAVE) begin
            beat_addr = {1'b1, addr_q};
            beat_data = payload_q[DATA_WIDTH-1:0];
        end

        core_onehot = '0;
        for (int n = 0; n < N_CORES; n++) begin
            core_onehot[n] = (32'(core_q) == 32'(n));
        end

        hold_addr_d = beat_addr;
        hold_data_d = beat_data;
    end

    // Outputs are forced quiet while reset is held, not just after it is sampled.
    always_comb begin
        mem_write_en   = (in_beat && !reset) ? core_onehot : '0;
        mem_write_addr = reset ? 13'd0 : beat_addr;
        mem_write_data = reset ? '0 : beat_data;
        busy           = in_beat && !reset;
        err_core       = err_q && !reset;
        dbg_state      = state_q;
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        last_gnt_d = last_gnt_q;
        core_d     = core_q;
        addr_d     = addr_q;
        payload_d  = payload_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_gnt_d = gnt;
                    if (core_ok) begin
                        core_d    = sel_core;
                        addr_d    = sel_addr;
                        payload_d = sel_data;
                        beat_d    = 2'd0;
                        state_d   = sel_wave ? ST_WAVE : ST_CMD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CMD: begin
                if (beat_q == 2'd3) begin
                    state_d = ST_IDLE;
                    beat_d  = 2'd0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            ST_WAVE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= 2'd0;
            last_gnt_q  <= 1'b1;
            core_q      <= '0;
            addr_q      <= '0;
            payload_q   <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            last_gnt_q  <= last_gnt_d;
            core_q      <= core_d;
            addr_q      <= addr_d;
            payload_q   <= payload_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dsp_mem_loader.sv
// Directed bench for dsp_mem_loader: command, wave, arbitration, bad core,
// reset abort and payload stability, each checked against hand-computed values.
module tb_dsp_mem_loader;

    localparam int N_CORES = 4;
    localparam int CSW     = 3;
    localparam int DW      = 32;
    localparam int CW      = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*CSW-1:0] req_core;
    logic [1:0]      req_is_wave;
    logic [23:0]     req_addr;
    logic [2*CW-1:0] req_data;
    logic [12:0]     mem_write_addr;
    logic [DW-1:0]   mem_write_data;
    logic [N_CORES-1:0] mem_write_en;
    logic            busy;
    logic            err_core;
    logic [1:0]      dbg_state;

    int vectors = 0;
    int fails   = 0;

    dsp_mem_loader #(
        .N_CORES(N_CORES), .CORE_SEL_WIDTH(CSW), .DATA_WIDTH(DW), .CMD_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_core(req_core), .req_is_wave(req_is_wave),
        .req_addr(req_addr), .req_data(req_data),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .busy(busy), .err_core(err_core),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_data();
        for (int j = 0; j < 8; j++) req_data[j*32 +: 32] = $urandom;
    endtask

    initial begin
        logic [127:0] p0;
        logic [127:0] p1;
        logic [1:0]   exp_gnt;

        reset = 1'b1; req_valid = 2'b00; req_core = '0; req_is_wave = 2'b00;
        req_addr = '0; req_data = '0;
        tick(); tick();
        req_valid = 2'b01;
        tick();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_en", 64'(mem_write_en), 64'h0);
        chk("rst_addr", 64'(mem_write_addr), 64'h0);
        chk("rst_data", 64'(mem_write_data), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(err_core), 64'h0);
        chk("rst_state", 64'(dbg_state), 64'h0);
        req_valid = 2'b00;
        reset = 1'b0;
        tick();

        // Command write from host, payload scrambled on the bus every beat.
        req_valid = 2'b01; req_core = {3'd0, 3'd2}; req_is_wave = 2'b00;
        req_addr = {12'h000, 12'h015};
        req_data = {128'h0, 128'h44444444_33333333_22222222_11111111};
        #1;
        chk("cmd_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            chk("cmd_en", 64'(mem_write_en), 64'h4);
            chk("cmd_addr", 64'(mem_write_addr), 64'(13'h015 + 13'(k) * 13'h100));
            chk("cmd_data", 64'(mem_write_data), 64'(32'h11111111 * (k + 1)));
            chk("cmd_busy", 64'(busy), 64'h1);
            scramble_data();
            tick();
        end
        chk("cmd_end_en", 64'(mem_write_en), 64'h0);
        chk("cmd_hold_addr", 64'(mem_write_addr), 64'h315);
        chk("cmd_hold_data", 64'(mem_write_data), 64'h44444444);
        chk("cmd_end_busy", 64'(busy), 64'h0);

        // Wave write from DMA.
        req_valid = 2'b10; req_core = {3'd0, 3'd0}; req_is_wave = 2'b10;
        req_addr = {12'hABC, 12'h000};
        req_data = {96'h0, 32'hDEADBEEF, 128'h0};
        #1;
        chk("wave_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        chk("wave_en", 64'(mem_write_en), 64'h1);
        chk("wave_addr", 64'(mem_write_addr), 64'h1ABC);
        chk("wave_data", 64'(mem_write_data), 64'hDEADBEEF);
        chk("wave_busy", 64'(busy), 64'h1);
        tick();
        chk("wave_busy_end", 64'(busy), 64'h0);
        chk("wave_en_end", 64'(mem_write_en), 64'h0);
        chk("wave_hold_addr", 64'(mem_write_addr), 64'h1ABC);

        // Round-robin with both requesters continuously valid after reset.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        p0 = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        p1 = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
        req_valid = 2'b11; req_core = {3'd3, 3'd1}; req_is_wave = 2'b00;
        req_addr = {12'h033, 12'h022}; req_data = {p1, p0};
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("arb_ready", 64'(req_ready), 64'(exp_gnt));
            chk("arb_idle", 64'(busy), 64'h0);
            tick();
            for (int k = 0; k < 4; k++) begin
                chk("arb_en", 64'(mem_write_en), (i % 2 == 0) ? 64'h2 : 64'h8);
                chk("arb_addr", 64'(mem_write_addr),
                    64'(((i % 2 == 0) ? 13'h022 : 13'h033) + 13'(k) * 13'h100));
                chk("arb_data", 64'(mem_write_data),
                    64'(((i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB0B0B0B0) + 32'h01010101 * k));
                chk("arb_busy_ready", 64'(req_ready), 64'h0);
                tick();
            end
        end
        req_valid = 2'b00;
        #1;
        chk("arb_hold_addr", 64'(mem_write_addr), 64'h333);
        chk("arb_hold_data", 64'(mem_write_data), 64'hB3B3B3B3);
        chk("arb_end_en", 64'(mem_write_en), 64'h0);

        // Invalid core index.
        req_valid = 2'b01; req_core = {3'd0, 3'd5}; req_is_wave = 2'b00;
        req_addr = {12'h000, 12'h007}; req_data = {128'h0, 128'h1234};
        #1;
        chk("bad_ready", 64'(req_ready), 64'h1);
        tick();
        chk("bad_err", 64'(err_core), 64'h1);
        chk("bad_en", 64'(mem_write_en), 64'h0);
        chk("bad_busy", 64'(busy), 64'h0);
        chk("bad_ready_again", 64'(req_ready), 64'h1);
        chk("bad_hold_addr", 64'(mem_write_addr), 64'h333);
        req_valid = 2'b00;
        tick();
        chk("bad_err_end", 64'(err_core), 64'h0);
        chk("bad_en_end", 64'(mem_write_en), 64'h0);

        // Reset during command beat 1 aborts the sequence for good.
        req_valid = 2'b01; req_core = {3'd0, 3'd1}; req_is_wave = 2'b00;
        req_addr = {12'h000, 12'h044};
        req_data = {128'h0, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0};
        #1;
        chk("abort_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        chk("abort_b0_en", 64'(mem_write_en), 64'h2);
        chk("abort_b0_addr", 64'(mem_write_addr), 64'h044);
        tick();
        chk("abort_b1_en", 64'(mem_write_en), 64'h2);
        chk("abort_b1_addr", 64'(mem_write_addr), 64'h144);
        reset = 1'b1;
        tick();
        chk("abort_rst_en", 64'(mem_write_en), 64'h0);
        chk("abort_rst_state", 64'(dbg_state), 64'h0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_post_en", 64'(mem_write_en), 64'h0);
            chk("abort_post_busy", 64'(busy), 64'h0);
            chk("abort_post_state", 64'(dbg_state), 64'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
